// File: rtl/oq_regs_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// oq_regs_rmw_ctrl
//   Read-modify-write sequencer for port A of the per-queue counter RAM.
//   Round-robin arbitration between three requesters:
//     - packet-stored (add, saturating at all-ones)
//     - packet-removed (subtract, saturating at zero)
//     - host register access (read or write)
//   Only one operation is in flight at a time, and every operation takes a
//   fixed three cycles (IDLE -> READ -> WRITE).
//
// Ports
//   clk_i, reset_i               core clock, async active-high reset
//   add_req_i/queue/amount       add request (held until add_ack_o)
//   add_ack_o                    1-cycle pulse when the add commits
//   sub_req_i/queue/amount       subtract request (held until sub_ack_o)
//   sub_ack_o                    1-cycle pulse when the subtract commits
//   reg_req_i, reg_rd_wr_L_i     host request, 1 = read, 0 = write
//   reg_queue_i, reg_wr_data_i   host target queue and write data
//   reg_ack_o                    1-cycle pulse when the host access completes
//   reg_rd_data_o                old RAM word; valid in the ack cycle, held after
//   ram_addr_o/we_o/din_o        RAM port A address, write enable, write data
//   ram_dout_i                   RAM port A read data (1-cycle latency)
//   ovf_err_o, unf_err_o         1-cycle pulses when an add/subtract saturates
//
// States
//   IDLE  | arbitrate, latch winner's queue and operands, present address
//   READ  | RAM reads the addressed entry
//   WRITE | old value on ram_dout_i; compute/commit the new value, pulse ack
// -----------------------------------------------------------------------------
module oq_regs_rmw_ctrl #(
    parameter int REG_WIDTH         = 32,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int QUEUE_ADDR_WIDTH  = $clog2(NUM_OUTPUT_QUEUES),
    parameter int AMOUNT_WIDTH      = 12
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        add_req_i,
    input  logic [QUEUE_ADDR_WIDTH-1:0] add_queue_i,
    input  logic [AMOUNT_WIDTH-1:0]     add_amount_i,
    output logic                        add_ack_o,

    input  logic                        sub_req_i,
    input  logic [QUEUE_ADDR_WIDTH-1:0] sub_queue_i,
    input  logic [AMOUNT_WIDTH-1:0]     sub_amount_i,
    output logic                        sub_ack_o,

    input  logic                        reg_req_i,
    input  logic                        reg_rd_wr_L_i,
    input  logic [QUEUE_ADDR_WIDTH-1:0] reg_queue_i,
    input  logic [REG_WIDTH-1:0]        reg_wr_data_i,
    output logic                        reg_ack_o,
    output logic [REG_WIDTH-1:0]        reg_rd_data_o,

    output logic [QUEUE_ADDR_WIDTH-1:0] ram_addr_o,
    output logic                        ram_we_o,
    output logic [REG_WIDTH-1:0]        ram_din_o,
    input  logic [REG_WIDTH-1:0]        ram_dout_i,

    output logic                        ovf_err_o,
    output logic                        unf_err_o
);

    localparam int RW = REG_WIDTH;
    localparam int QW = QUEUE_ADDR_WIDTH;
    localparam int AW = AMOUNT_WIDTH;
    localparam logic [QW:0] NUM_Q = (QW+1)'(NUM_OUTPUT_QUEUES);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
    typedef enum logic [1:0] {SRC_REG = 2'd0, SRC_ADD = 2'd1, SRC_SUB = 2'd2} src_t;

    state_t          state_q;
    src_t            src_q;
    src_t            rr_q;
    logic [QW-1:0]   ram_addr_q;
    logic [AW-1:0]   amount_q;
    logic [RW-1:0]   wr_data_q;
    logic            rd_q;
    logic [RW-1:0]   reg_rd_data_q;

    logic            grant_valid;
    src_t            grant_src;
    logic [QW-1:0]   grant_queue;

    logic [RW:0]     amount_ext;
    logic [RW:0]     sum_w;
    logic [RW:0]     diff_w;
    logic [RW-1:0]   din_sel;
    logic [RW-1:0]   old_rd;
    logic            in_write;
    logic            in_range;

    // Round-robin: search starts at the requester after the last winner.
    always_comb begin
        grant_valid = add_req_i | sub_req_i | reg_req_i;
        grant_src   = SRC_REG;
        case (rr_q)
            SRC_REG: begin
                if (add_req_i)      grant_src = SRC_ADD;
                else if (sub_req_i) grant_src = SRC_SUB;
                else                grant_src = SRC_REG;
            end
            SRC_ADD: begin
                if (sub_req_i)      grant_src = SRC_SUB;
                else if (reg_req_i) grant_src = SRC_REG;
                else                grant_src = SRC_ADD;
            end
            default: begin
                if (reg_req_i)      grant_src = SRC_REG;
                else if (add_req_i) grant_src = SRC_ADD;
                else                grant_src = SRC_SUB;
            end
        endcase
        case (grant_src)
            SRC_ADD: grant_queue = add_queue_i;
            SRC_SUB: grant_queue = sub_queue_i;
            default: grant_queue = reg_queue_i;
        endcase
    end

    // One extra bit catches carry-out / borrow for saturation.
    assign amount_ext = {{(RW+1-AW){1'b0}}, amount_q};
    assign sum_w      = {1'b0, ram_dout_i} + amount_ext;
    assign diff_w     = {1'b0, ram_dout_i} - amount_ext;

    assign in_write = (state_q == S_WRITE);
    assign in_range = ({1'b0, ram_addr_q} < NUM_Q);
    assign old_rd   = in_range ? ram_dout_i : '0;

    always_comb begin
        din_sel = wr_data_q;
        case (src_q)
            SRC_ADD: din_sel = sum_w[RW]  ? '1 : sum_w[RW-1:0];
            SRC_SUB: din_sel = diff_w[RW] ? '0 : diff_w[RW-1:0];
            default: din_sel = wr_data_q;
        endcase
    end

    // WRITE-cycle outputs depend on ram_dout_i, which is only valid in that
    // cycle, so they are decoded from the registered state rather than stored.
    assign add_ack_o     = in_write && (src_q == SRC_ADD);
    assign sub_ack_o     = in_write && (src_q == SRC_SUB);
    assign reg_ack_o     = in_write && (src_q == SRC_REG);
    assign ram_we_o      = in_write && in_range && !((src_q == SRC_REG) && rd_q);
    assign ram_din_o     = ram_we_o ? din_sel : '0;
    assign ovf_err_o     = add_ack_o && in_range && sum_w[RW];
    assign unf_err_o     = sub_ack_o && in_range && diff_w[RW];
    assign ram_addr_o    = ram_addr_q;
    assign reg_rd_data_o = reg_ack_o ? old_rd : reg_rd_data_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            src_q         <= SRC_REG;
            rr_q          <= SRC_SUB;
            ram_addr_q    <= '0;
            amount_q      <= '0;
            wr_data_q     <= '0;
            rd_q          <= 1'b0;
            reg_rd_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        src_q      <= grant_src;
                        rr_q       <= grant_src;
                        ram_addr_q <= grant_queue;
                        amount_q   <= (grant_src == SRC_ADD) ? add_amount_i : sub_amount_i;
                        wr_data_q  <= reg_wr_data_i;
                        rd_q       <= reg_rd_wr_L_i;
                        state_q    <= S_READ;
                    end
                end
                S_READ: begin
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (src_q == SRC_REG) begin
                        reg_rd_data_q <= old_rd;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
